// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S RAM arbiter: owner encoding and wait-counter width.
package k_and_s_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } arb_owner_t;

    localparam int ARB_WAIT_W = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating loss counter for the arbiter. Clear with inc set restarts the count at 1,
// so a new loser's first lost cycle is counted in the same cycle the old loser wins.
module arb_wait_counter
    import k_and_s_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_inc,
    input  logic                  i_clr,
    output logic [ARB_WAIT_W-1:0] o_cnt,
    output logic                  o_sat
);

    localparam logic [ARB_WAIT_W-1:0] LP_MAX = ARB_WAIT_W'(MAX_WAIT);
    localparam logic [ARB_WAIT_W-1:0] LP_ONE = ARB_WAIT_W'(1);

    logic [ARB_WAIT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_inc ? LP_ONE : '0;
        end else if (i_inc && (r_cnt != LP_MAX)) begin
            r_cnt <= r_cnt + LP_ONE;
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = (r_cnt == LP_MAX);

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between the K&S CPU and a DMA/loader port: CPU priority,
// bounded loser wait, DMA burst lock, one-cycle read-valid pipeline per port.
module ram_arbiter
    import k_and_s_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    input  logic                  dma_lock,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    arb_owner_t            r_owner;
    arb_owner_t            w_owner_nxt;
    logic                  w_both;
    logic                  w_dma_wins;
    logic                  w_cpu_gnt;
    logic                  w_dma_gnt;
    logic                  w_cnt_inc;
    logic                  w_cnt_clr;
    logic                  w_sat;
    logic [ARB_WAIT_W-1:0] w_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic [DATA_WIDTH-1:0] r_last_wdata;
    logic                  r_cpu_rvalid;
    logic                  r_dma_rvalid;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_dma_rdata;

    assign w_both = cpu_req && dma_req;

    // Counter follows whoever lost; a change of winner under contention restarts it.
    assign w_cnt_inc = w_both;
    assign w_cnt_clr = !w_both || (w_owner_nxt != r_owner);

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_cnt_inc),
        .i_clr (w_cnt_clr),
        .o_cnt (w_wait_cnt),
        .o_sat (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // A saturated counter means the previous cycle's loser (the non-owner) must win now.
    always_comb begin
        w_dma_wins = 1'b0;
        if (!rst_n) begin
            w_dma_wins = 1'b0;
        end else if (!w_both) begin
            w_dma_wins = dma_req;
        end else if (w_sat) begin
            w_dma_wins = (r_owner == OWN_CPU);
        end else begin
            w_dma_wins = (r_owner == OWN_DMA) && dma_lock;
        end
        w_cpu_gnt = rst_n && cpu_req && !w_dma_wins;
        w_dma_gnt = w_dma_wins;
        w_owner_nxt = OWN_NONE;
        if (w_cpu_gnt) begin
            w_owner_nxt = OWN_CPU;
        end else if (w_dma_gnt) begin
            w_owner_nxt = OWN_DMA;
        end
    end

    always_comb begin
        cpu_gnt   = w_cpu_gnt;
        dma_gnt   = w_dma_gnt;
        ram_we    = 1'b0;
        ram_addr  = r_last_addr;
        ram_wdata = r_last_wdata;
        if (w_cpu_gnt) begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (w_dma_gnt) begin
            ram_we    = dma_we;
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
        end
    end

    // Idle cycles keep the RAM bus at the last issued address and data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_addr  <= '0;
            r_last_wdata <= '0;
        end else begin
            r_last_addr  <= ram_addr;
            r_last_wdata <= ram_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
        end else begin
            r_cpu_rvalid <= w_cpu_gnt && !cpu_we;
            r_dma_rvalid <= w_dma_gnt && !dma_we;
            if (r_cpu_rvalid) begin
                r_cpu_rdata <= ram_rdata;
            end
            if (r_dma_rvalid) begin
                r_dma_rdata <= ram_rdata;
            end
        end
    end

    assign cpu_rvalid = r_cpu_rvalid;
    assign dma_rvalid = r_dma_rvalid;
    assign cpu_rdata  = r_cpu_rvalid ? ram_rdata : r_cpu_rdata;
    assign dma_rdata  = r_dma_rvalid ? ram_rdata : r_dma_rdata;

`ifndef SYNTHESIS
    a_cpu_cmd_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (cpu_req && !cpu_gnt) |=> (!cpu_req || $stable({cpu_we, cpu_addr, cpu_wdata})));
    a_dma_cmd_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (dma_req && !dma_gnt) |=> (!dma_req || $stable({dma_we, dma_addr, dma_wdata})));
    a_wait_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        w_wait_cnt <= ARB_WAIT_W'(MAX_WAIT));
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: grant sequences checked inline, read data via scoreboard queues.
module tb_ram_arbiter;
    import k_and_s_pkg::*;

    localparam int AW = 5;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [AW-1:0] cpu_addr, dma_addr, ram_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, ram_wdata, ram_rdata;
    logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, ram_we;
    logic [DW-1:0] cpu_rdata, dma_rdata;
    logic          preload;

    logic [DW-1:0] mem [0:31];
    logic [DW-1:0] q_cpu [$];
    logic [DW-1:0] q_dma [$];
    int            n_cmp  = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .dma_lock(dma_lock),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Write-first RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            mem[3] <= 16'hA5A5;
            mem[5] <= 16'h5A5A;
            ram_rdata <= '0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= ram_we ? ram_wdata : mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rvalid must match the oldest expected read.
    always @(negedge clk) begin
        if (cpu_rvalid) begin
            if (q_cpu.size() == 0) chk("cpu_rvalid spurious", {31'd0, cpu_rvalid}, 32'd0);
            else chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, q_cpu.pop_front()});
        end
        if (dma_rvalid) begin
            if (q_dma.size() == 0) chk("dma_rvalid spurious", {31'd0, dma_rvalid}, 32'd0);
            else chk("dma_rdata", {16'd0, dma_rdata}, {16'd0, q_dma.pop_front()});
        end
    end

    task automatic drv(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                       input logic dl);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_lock = dl;
    endtask

    task automatic tick_chk(input string name, input logic ecg, input logic edg,
                            input logic [DW-1:0] ecd, input logic [DW-1:0] edd);
        @(negedge clk);
        chk({name, " cpu_gnt"}, {31'd0, cpu_gnt}, {31'd0, ecg});
        chk({name, " dma_gnt"}, {31'd0, dma_gnt}, {31'd0, edg});
        if (ecg && !cpu_we) q_cpu.push_back(ecd);
        if (edg && !dma_we) q_dma.push_back(edd);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic ecg, input logic edg,
                        input logic [DW-1:0] ecd, input logic [DW-1:0] edd);
        tick_chk(name, ecg, edg, ecd, edd);
        adv();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [9:0] pat;
        rst_n   = 1'b0;
        preload = 1'b1;
        drv(1, 0, 5'd3, 16'h0, 0, 0, 5'd0, 16'h0, 0);
        adv();
        preload = 1'b0;

        // Reset state with a CPU request pending
        @(negedge clk);
        chk("rst cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        chk("rst ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst ram_addr", {27'd0, ram_addr}, 32'd0);
        chk("rst ram_wdata", {16'd0, ram_wdata}, 32'd0);
        chk("rst cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        chk("rst dma_rdata", {16'd0, dma_rdata}, 32'd0);
        chk("rst owner", {30'd0, dut.r_owner}, {30'd0, OWN_NONE});
        adv();
        drv(0, 0, 5'd0, 16'h0, 0, 0, 5'd0, 16'h0, 0);
        rst_n = 1'b1;
        step("idle0", 0, 0, 0, 0);

        // CPU-only read of address 3
        drv(1, 0, 5'd3, 16'h0, 0, 0, 5'd0, 16'h0, 0);
        tick_chk("t1 read", 1, 0, 16'hA5A5, 0);
        chk("t1 ram_addr", {27'd0, ram_addr}, 32'd3);
        chk("t1 ram_we", {31'd0, ram_we}, 32'd0);
        adv();
        drv(0, 0, 5'd3, 16'h0, 0, 0, 5'd0, 16'h0, 0);
        tick_chk("t1 after", 0, 0, 0, 0);
        chk("t1 cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        chk("t1 ram_addr hold", {27'd0, ram_addr}, 32'd3);
        adv();
        tick_chk("t1 hold", 0, 0, 0, 0);
        chk("t1 rdata hold", {16'd0, cpu_rdata}, 32'hA5A5);
        chk("t1 rvalid low", {31'd0, cpu_rvalid}, 32'd0);
        adv();

        // Continuous contention: four CPU grants, then one DMA grant, repeated
        pat = 10'b10000_10000;
        drv(1, 0, 5'd3, 16'h0, 1, 0, 5'd5, 16'h0, 0);
        for (int i = 0; i < 10; i++) step("t2 contention", !pat[i], pat[i], 16'hA5A5, 16'h5A5A);
        drv(0, 0, 5'd3, 16'h0, 0, 0, 5'd5, 16'h0, 0);
        step("t2 end", 0, 0, 0, 0);

        // DMA burst lock holds off the CPU until the wait bound, lock drop restores CPU priority
        drv(0, 0, 5'd3, 16'h0, 1, 1, 5'd10, 16'h0BEE, 1);
        step("t3 dma own", 0, 1, 0, 0);
        drv(1, 0, 5'd3, 16'h0, 1, 1, 5'd10, 16'h0BEE, 1);
        for (int i = 0; i < 4; i++) step("t3 locked", 0, 1, 0, 0);
        step("t3 bound", 1, 0, 16'hA5A5, 0);
        drv(0, 0, 5'd3, 16'h0, 1, 1, 5'd10, 16'h0BEE, 1);
        step("t3 reown", 0, 1, 0, 0);
        drv(1, 0, 5'd3, 16'h0, 1, 1, 5'd10, 16'h0BEE, 1);
        step("t3 relock", 0, 1, 0, 0);
        drv(1, 0, 5'd3, 16'h0, 1, 1, 5'd10, 16'h0BEE, 0);
        step("t3 unlock", 1, 0, 16'hA5A5, 0);
        step("t3 cpu prio", 1, 0, 16'hA5A5, 0);
        drv(0, 0, 5'd3, 16'h0, 0, 1, 5'd10, 16'h0BEE, 0);
        step("t3 end", 0, 0, 0, 0);

        // DMA write then CPU read of the same address
        drv(0, 0, 5'd7, 16'h0, 1, 1, 5'd7, 16'h1234, 0);
        tick_chk("t4 write", 0, 1, 0, 0);
        chk("t4 ram_we", {31'd0, ram_we}, 32'd1);
        chk("t4 ram_wdata", {16'd0, ram_wdata}, 32'h1234);
        adv();
        drv(1, 0, 5'd7, 16'h0, 0, 1, 5'd7, 16'h1234, 0);
        step("t4 read", 1, 0, 16'h1234, 0);
        drv(0, 0, 5'd7, 16'h0, 0, 0, 5'd7, 16'h0, 0);
        step("t4 end", 0, 0, 0, 0);

        // Reset asserted the cycle after a granted read drops its rvalid
        drv(1, 0, 5'd3, 16'h0, 0, 0, 5'd0, 16'h0, 0);
        @(negedge clk);
        chk("t5 cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
        adv();
        drv(0, 0, 5'd3, 16'h0, 0, 0, 5'd0, 16'h0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5 cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("t5 ram_we", {31'd0, ram_we}, 32'd0);
        chk("t5 ram_addr", {27'd0, ram_addr}, 32'd0);
        chk("t5 cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        chk("t5 owner", {30'd0, dut.r_owner}, {30'd0, OWN_NONE});
        adv();
        rst_n = 1'b1;

        // Idle: nothing issued, counter stays clear
        for (int i = 0; i < 10; i++) begin
            tick_chk("t6 idle", 0, 0, 0, 0);
            chk("t6 ram_we", {31'd0, ram_we}, 32'd0);
            chk("t6 wait_cnt", {28'd0, dut.w_wait_cnt}, 32'd0);
            adv();
        end

        chk("cpu queue drained", q_cpu.size(), 32'd0);
        chk("dma queue drained", q_dma.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
